guess_checker: RTL
==================

Name: guess_checker

Overview:
Guessing-side counterpart of the hangman word-entry datapath. Player 1's word sits in the 32x5 character RAM at addresses 0..wordlength-1. This block accepts player 2's guessed characters and scans the RAM through its read port for each guess. It maintains the revealed-position mask, the remaining-letter count and the hangman miss count, and raises win/lose for the score logic and the VGA draw logic.

Parameters:
CHAR_W, 5, character code width (matches RAM data width)
ADDR_W, 5, RAM address width
MAX_LEN, 16, maximum word length; width of the revealed mask
MAX_MISS, 9, misses that complete the hangman figure (lose)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: begin new round, latch wordlength
wordlength  in  ADDR_W  word length from the entry datapath
guess_valid  in  1  guess_char is valid
guess_char  in  CHAR_W  guessed character code
guess_ready  out  1  block can accept a guess
rd_addr  out  ADDR_W  RAM read address
rd_data  in  CHAR_W  RAM q; synchronous read, 1-cycle latency
revealed  out  MAX_LEN  bit i=1: position i is uncovered
match_count  out  ADDR_W  newly revealed positions from the last guess
remaining  out  ADDR_W  covered positions left
misses  out  4  wrong guesses so far
hit  out  1  one-cycle pulse: last guess matched at least one position
miss  out  1  one-cycle pulse: last guess matched nothing (draw next part)
win  out  1  level: remaining==0 within a round
lose  out  1  level: misses==MAX_MISS
busy  out  1  scan in progress

Behaviour:
- Reset values: all outputs 0. State OFF; no round active until start.
- States: OFF, READY, SCAN, RESULT, OVER.
- start, accepted in any state, is the highest priority except reset:
  - len = min(wordlength, MAX_LEN); revealed=0; remaining=len; misses=0; match_count=0; scan aborted.
  - Next state is READY, or OVER with win=1 when len==0.
- start and guess_valid in the same cycle: the guess is not accepted.
- guess_ready=1 only in READY. A guess is accepted on the edge where guess_valid&&guess_ready. At that edge the block latches guess_char, sets rd_addr=0 and busy=1, and enters SCAN.
- SCAN:
  - rd_addr increments each cycle up to len-1.
  - An index delayed by one cycle pairs with rd_data.
  - For each index i<len with rd_data==latched char: set any_match; if revealed[i]==0, set revealed[i] and increment the new-match counter.
  - revealed is updated during the scan and the count is committed in RESULT.
- Latency: with accept edge at cycle 0, the RESULT cycle is cycle len+2.
- RESULT (one cycle): hit=any_match, miss=!any_match, match_count=new matches, remaining-=new matches, busy=0.
- On a miss, misses increments and saturates at MAX_MISS.
- Next state after RESULT: OVER if remaining==0 (win=1) or misses==MAX_MISS (lose=1), else READY.
- Re-guessing an already revealed letter gives hit=1, match_count=0, remaining unchanged; it is not a miss.
- OVER: guess_ready=0. win/lose and all counters hold until the next start or reset.
- rd_addr holds its last value outside SCAN. Positions >= len are never read.
- Asynchronous reset mid-scan returns the block to OFF immediately with all outputs 0.
- Width rules:
  - remaining is never decremented below 0.
  - match_count <= len.
  - win and lose are never both 1; lose can only be raised by a miss, and a miss never reduces remaining.

Test Plan:
- RAM[0..3]={1,2,3,1}; start, wordlength=4; guess 1 -> hit pulse at cycle 6, match_count=2, revealed=16'h0009, remaining=2, misses=0.
- Same round: guess 5 -> miss pulse, misses=1, revealed unchanged. Guess 1 again -> hit, match_count=0, remaining=2.
- Guess 2 then 3 -> remaining 1 then 0, revealed=16'h000F, win=1, guess_ready=0; a further guess_valid is ignored.
- New start, wordlength=4; nine misses (char 7) -> misses=9, lose=1 after the ninth RESULT, win=0; a tenth guess is not accepted.
- Assert resetn during SCAN (cycle 2 after accept) -> all outputs 0 at once, state OFF. A start pulse mid-scan instead -> READY, revealed=0, no hit/miss pulse.
- start with wordlength=0 -> win=1 the next cycle. start with wordlength=20 -> remaining=16 and the scan reads addresses 0..15 only.

Source files
------------

// File: rtl/guess_checker_if.sv
// Guess handshake and character-RAM read port for guess_checker.
// The slave side is the checker; the master side is the guess source plus the RAM.
interface guess_checker_if #(
    parameter int CHAR_W = 5,
    parameter int ADDR_W = 5
);
    logic              guess_valid;
    logic [CHAR_W-1:0] guess_char;
    logic              guess_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [CHAR_W-1:0] rd_data;

    modport master (
        output guess_valid,
        output guess_char,
        output rd_data,
        input  guess_ready,
        input  rd_addr
    );

    modport slave (
        input  guess_valid,
        input  guess_char,
        input  rd_data,
        output guess_ready,
        output rd_addr
    );
endinterface

// File: rtl/guess_checker.sv
// Hangman guess checker: scans the word RAM for each guessed character and tracks
// the revealed mask, remaining letters and miss count for the score and draw logic.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_OFF    | no round since reset; waits for start
// S_READY  | round active, guess_ready=1, waiting for a guess
// S_SCAN   | reading RAM[0..len-1] and comparing against the latched guess
// S_RESULT | one cycle: hit/miss pulse, match_count and remaining committed
// S_OVER   | round finished (win or lose); everything holds until start
module guess_checker #(
    parameter int CHAR_W   = 5,
    parameter int ADDR_W   = 5,
    parameter int MAX_LEN  = 16,
    parameter int MAX_MISS = 9
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  wordlength,
    guess_checker_if.slave     bus,
    output logic [MAX_LEN-1:0] revealed,
    output logic [ADDR_W-1:0]  match_count,
    output logic [ADDR_W-1:0]  remaining,
    output logic [3:0]         misses,
    output logic               hit,
    output logic               miss,
    output logic               win,
    output logic               lose,
    output logic               busy
);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_OFF,
        S_READY,
        S_SCAN,
        S_RESULT,
        S_OVER
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] len_start;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] new_cnt;
    logic [CHAR_W-1:0] scan_char;
    logic              issuing;
    logic              vld_d;
    logic              scan_done;
    logic              any_match;
    logic              accept;
    logic              char_eq;

    assign len_start = (wordlength > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : wordlength;
    // A start in the same cycle as guess_valid wins; the guess is dropped.
    assign accept    = bus.guess_valid && (state == S_READY) && !start;
    // vld_d/idx_d trail rd_addr by one edge so they line up with the RAM's registered q.
    assign char_eq   = vld_d && (bus.rd_data == scan_char);
    assign bus.rd_addr = rd_addr;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= S_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.guess_ready = 1'b0;
        busy            = 1'b0;
        hit             = 1'b0;
        miss            = 1'b0;
        win             = 1'b0;
        lose            = 1'b0;

        case (state)
            S_OFF:    state_nxt = S_OFF;
            S_READY:  if (accept) state_nxt = S_SCAN;
            S_SCAN:   if (scan_done) state_nxt = S_RESULT;
            S_RESULT: begin
                if (remaining == '0 || misses == 4'(MAX_MISS)) begin
                    state_nxt = S_OVER;
                end else begin
                    state_nxt = S_READY;
                end
            end
            S_OVER:   state_nxt = S_OVER;
            default:  state_nxt = S_OFF;
        endcase

        if (start) begin
            state_nxt = (len_start == '0) ? S_OVER : S_READY;
        end

        bus.guess_ready = (state == S_READY);
        busy            = (state == S_SCAN);
        hit             = (state == S_RESULT) && any_match;
        miss            = (state == S_RESULT) && !any_match;
        win             = (state != S_OFF) && (remaining == '0);
        lose            = (misses == 4'(MAX_MISS));
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            len         <= '0;
            rd_addr     <= '0;
            idx_d       <= '0;
            new_cnt     <= '0;
            scan_char   <= '0;
            issuing     <= 1'b0;
            vld_d       <= 1'b0;
            scan_done   <= 1'b0;
            any_match   <= 1'b0;
            revealed    <= '0;
            match_count <= '0;
            remaining   <= '0;
            misses      <= '0;
        end else if (start) begin
            len         <= len_start;
            revealed    <= '0;
            remaining   <= len_start;
            misses      <= '0;
            match_count <= '0;
            new_cnt     <= '0;
            issuing     <= 1'b0;
            vld_d       <= 1'b0;
            scan_done   <= 1'b0;
            any_match   <= 1'b0;
        end else begin
            case (state)
                S_READY: begin
                    if (accept) begin
                        scan_char <= bus.guess_char;
                        rd_addr   <= '0;
                        issuing   <= 1'b1;
                        vld_d     <= 1'b0;
                        scan_done <= 1'b0;
                        any_match <= 1'b0;
                        new_cnt   <= '0;
                    end
                end
                S_SCAN: begin
                    vld_d <= issuing;
                    idx_d <= rd_addr;
                    // Address stops at len-1 so positions beyond the word are never read.
                    if (issuing) begin
                        if (rd_addr == len - ADDR_W'(1)) begin
                            issuing <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                    if (char_eq) begin
                        any_match <= 1'b1;
                        if (!revealed[idx_d[IDX_W-1:0]]) begin
                            revealed[idx_d[IDX_W-1:0]] <= 1'b1;
                            new_cnt <= new_cnt + ADDR_W'(1);
                        end
                    end
                    if (vld_d && (idx_d == len - ADDR_W'(1))) begin
                        scan_done <= 1'b1;
                    end
                    if (scan_done) begin
                        match_count <= new_cnt;
                        remaining   <= (new_cnt > remaining) ? '0 : remaining - new_cnt;
                        if (!any_match && misses != 4'(MAX_MISS)) begin
                            misses <= misses + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
